ship_heading_ctrl: RTL and testbench
====================================

# ship_heading_ctrl

Parametrised ship control core: converts debounced keyboard control levels (rotate left/right, thrust, fire) into a registered heading, a compass direction vector, a move flag and rate-limited single-cycle shot pulses. Sits between the keyboard decoder and the spaceship datapath. Heading resolution, step period and fire cooldown are configurable. A liveness input freezes the ship.

## Interface
- TICK_DIV, 12500000: clk cycles per control tick (≥2).
- HEADING_BITS, 3: heading index width; N = 2^HEADING_BITS headings (≥3).
- RESET_HEADING, 0: heading loaded at reset (0 = north, increasing clockwise).
- COOLDOWN_TICKS, 2: ticks between shots (0..255).
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- rotate_left  in  1  level, rotate counter-clockwise.
- rotate_right  in  1  level, rotate clockwise.
- thrust  in  1  level, move request.
- fire  in  1  level, shoot request.
- alive  in  1  ship alive (lives ≠ 0).
- heading  out  HEADING_BITS  current heading index.
- dir  out  4  compass vector {W,E,S,N} of current octant.
- move  out  1  move flag, held for one tick period.
- shot  out  1  one-cycle shot pulse.
- tick  out  1  one-cycle control tick strobe.

## Operation
- Tick counter: loads TICK_DIV-1 at reset, decrements each cycle, tick=1 in the cycle it reads 0, then reloads TICK_DIV-1.
- Rotation, evaluated only on tick with alive=1: right only → heading+1 mod N; left only → heading-1 mod N; both or neither → hold. Wrap: N-1+1 → 0, 0-1 → N-1.
- dir from octant o = heading[HEADING_BITS-1 -: 3]: o=0..7 → 0001,0101,0100,0110,0010,1010,1000,1001 (N,NE,E,SE,S,SW,W,NW).
- move: on tick, move ← thrust & alive; held between ticks.
- Fire FSM, states IDLE, FIRE, COOL:
  - IDLE: if alive & fire & armed → FIRE. armed = fire_q==0 (fire low in previous cycle), or always 1 per Configuration.
  - FIRE: shot=1 for exactly this cycle; cd ← COOLDOWN_TICKS; → COOL, or → IDLE if COOLDOWN_TICKS=0.
  - COOL: on tick, if cd==1 → IDLE else cd ← cd-1. Fire ignored in COOL.
- alive=0: heading/dir frozen, move forced 0 on next tick, shot never asserted, FIRE/COOL still complete to IDLE. Tick counter keeps running.
- fire_q: one-cycle registered copy of fire, reset 0.

## Timing
- All outputs registered. Reset values: heading=RESET_HEADING, dir=dir(RESET_HEADING), move=0, shot=0, tick=0, FSM=IDLE, cd=0, fire_q=0.
- heading/dir/move update in the cycle after tick=1.
- shot: 2 cycles after the fire rising edge is sampled (IDLE→FIRE cycle, then shot visible); at most one shot per cooldown.
- Minimum shot spacing: COOLDOWN_TICKS ticks after FIRE (first tick after FIRE counts as 1).
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous); first tick TICK_DIV cycles after deassertion.
- fire rising edge during COOL is lost; fire must be released and re-pressed once IDLE.

## Configuration
- SHIP_AUTOFIRE_EN defined: armed is constant 1; holding fire re-fires on every return to IDLE (period set by cooldown).
- Undefined: armed requires fire low in the prior cycle; held fire yields exactly one shot per press.

## Test plan
- TICK_DIV=4, HEADING_BITS=3, reset heading 0, rotate_right held 9 ticks → heading 1,2,…,7,0,1; dir 0101 after first tick, 0001 after eighth.
- rotate_left held from heading 0 → heading 7, dir 1001; both rotate inputs high for 3 ticks → heading unchanged.
- HEADING_BITS=4, right 3 ticks from 0 → heading 3, dir 0101 (octant 1).
- fire held 20 cycles, COOLDOWN_TICKS=2, autofire undefined → exactly one shot; with SHIP_AUTOFIRE_EN → repeated shots, spacing ≤ 3×TICK_DIV cycles, never two within COOL.
- alive=0 with thrust, fire, rotate_right held → move=0 after next tick, shot=0, heading frozen; alive=1 → resumes on next tick.
- Reset pulled low mid-COOL with heading=5 → heading=RESET_HEADING, shot=0, move=0 in same cycle; fire edge after release fires from IDLE.

Source files
------------

// File: rtl/ship_heading_ctrl_if.sv
// Control bundle between the keyboard decoder (master) and the ship control core (slave).
// The master drives the debounced key levels and the liveness flag.
// The slave returns the heading, compass vector, move flag, shot pulse and tick strobe.
interface ship_heading_ctrl_if #(
    parameter int unsigned HEADING_BITS = 3
);
    logic                    rotate_left;
    logic                    rotate_right;
    logic                    thrust;
    logic                    fire;
    logic                    alive;
    logic [HEADING_BITS-1:0] heading;
    logic [3:0]              dir;
    logic                    move;
    logic                    shot;
    logic                    tick;

    modport master (
        output rotate_left,
        output rotate_right,
        output thrust,
        output fire,
        output alive,
        input  heading,
        input  dir,
        input  move,
        input  shot,
        input  tick
    );

    modport slave (
        input  rotate_left,
        input  rotate_right,
        input  thrust,
        input  fire,
        input  alive,
        output heading,
        output dir,
        output move,
        output shot,
        output tick
    );
endinterface

// File: rtl/ship_heading_ctrl.sv
// Ship control core: turns debounced key levels into a registered heading, a compass
// direction vector {W,E,S,N}, a per-tick move flag and rate-limited one-cycle shot pulses.
// All motion state advances on a divided control tick; the fire path runs every cycle.
// Build option: define SHIP_AUTOFIRE_EN to let a held fire key re-fire on every return
// to idle; without it each press of fire yields exactly one shot.
module ship_heading_ctrl #(
    parameter int unsigned TICK_DIV       = 12500000,
    parameter int unsigned HEADING_BITS   = 3,
    parameter int unsigned RESET_HEADING  = 0,
    parameter int unsigned COOLDOWN_TICKS = 2
) (
    input logic                clk,
    input logic                reset,
    ship_heading_ctrl_if.slave bus
);
    localparam int unsigned CntBits = $clog2(TICK_DIV);

    localparam logic [CntBits-1:0]      CntReload    = CntBits'(TICK_DIV - 1);
    localparam logic [CntBits-1:0]      CntOne       = CntBits'(1);
    localparam logic [HEADING_BITS-1:0] HeadingReset = HEADING_BITS'(RESET_HEADING);
    localparam logic [7:0]              CdLoad       = 8'(COOLDOWN_TICKS);

    typedef enum logic [1:0] {
        StIdle,
        StFire,
        StCool
    } fire_state_e;

    // Compass vector of the octant given by the top three heading bits.
    function automatic logic [3:0] dir_of(input logic [HEADING_BITS-1:0] h);
        logic [2:0] oct;
        oct = h[HEADING_BITS-1 -: 3];
        case (oct)
            3'd0:    dir_of = 4'b0001;  // N
            3'd1:    dir_of = 4'b0101;  // NE
            3'd2:    dir_of = 4'b0100;  // E
            3'd3:    dir_of = 4'b0110;  // SE
            3'd4:    dir_of = 4'b0010;  // S
            3'd5:    dir_of = 4'b1010;  // SW
            3'd6:    dir_of = 4'b1000;  // W
            default: dir_of = 4'b1001;  // NW
        endcase
    endfunction

    logic [CntBits-1:0]      cnt_q, cnt_d;
    logic                    tick_q, tick_d;
    logic [HEADING_BITS-1:0] heading_q, heading_d;
    logic [3:0]              dir_q, dir_d;
    logic                    move_q, move_d;
    fire_state_e             state_q, state_d;
    logic [7:0]              cd_q, cd_d;
    logic                    shot_q, shot_d;
    logic                    fire_q;
    logic                    armed;

`ifdef SHIP_AUTOFIRE_EN
    assign armed = 1'b1;
`else
    // A shot needs a fresh press: fire must have been low in the previous cycle.
    assign armed = ~fire_q;
`endif

    // Tick divider: tick_q is registered so that it is high exactly while cnt_q reads 0.
    always_comb begin
        cnt_d  = cnt_q - 1'b1;
        tick_d = 1'b0;
        if (cnt_q == '0) begin
            cnt_d = CntReload;
        end
        if (cnt_q == CntOne) begin
            tick_d = 1'b1;
        end
    end

    // Tick divider state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= CntReload;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    // Heading and move flag advance only on tick; a dead ship freezes its heading.
    always_comb begin
        heading_d = heading_q;
        move_d    = move_q;
        if (tick_q) begin
            move_d = bus.thrust & bus.alive;
            if (bus.alive) begin
                if (bus.rotate_right && !bus.rotate_left) begin
                    heading_d = heading_q + 1'b1;
                end else if (bus.rotate_left && !bus.rotate_right) begin
                    heading_d = heading_q - 1'b1;
                end
            end
        end
        dir_d = dir_of(heading_d);
    end

    // Motion state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            heading_q <= HeadingReset;
            dir_q     <= dir_of(HeadingReset);
            move_q    <= 1'b0;
        end else begin
            heading_q <= heading_d;
            dir_q     <= dir_d;
            move_q    <= move_d;
        end
    end

    // Fire FSM: one FIRE cycle per accepted request, then COOL counts ticks down to idle.
    always_comb begin
        state_d = state_q;
        cd_d    = cd_q;
        shot_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.alive && bus.fire && armed) begin
                    state_d = StFire;
                end
            end
            StFire: begin
                // The pulse lands on the cycle after FIRE; a ship that died meanwhile stays silent.
                shot_d  = bus.alive;
                cd_d    = CdLoad;
                state_d = (CdLoad == 8'd0) ? StIdle : StCool;
            end
            StCool: begin
                // Fire requests are ignored here; only ticks move the cooldown along.
                if (tick_q) begin
                    if (cd_q <= 8'd1) begin
                        state_d = StIdle;
                    end else begin
                        cd_d = cd_q - 8'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Fire path registers, including the one-cycle copy of fire used for edge arming.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cd_q    <= 8'd0;
            shot_q  <= 1'b0;
            fire_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cd_q    <= cd_d;
            shot_q  <= shot_d;
            fire_q  <= bus.fire;
        end
    end

    assign bus.heading = heading_q;
    assign bus.dir     = dir_q;
    assign bus.move    = move_q;
    assign bus.shot    = shot_q;
    assign bus.tick    = tick_q;
endmodule

// File: tb/tb_ship_heading_ctrl.sv
// Bench for ship_heading_ctrl: expected heading/dir/move per tick are queued as stimulus
// is applied and compared when the tick's update becomes visible; shots are logged by cycle.
`timescale 1ns/1ps
module tb_ship_heading_ctrl;
    localparam int unsigned TickDiv  = 4;
    localparam int unsigned Cooldown = 2;

    typedef struct packed {
        logic [2:0] heading;
        logic [3:0] dir;
        logic       move;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_err = 0;
    int   n_chk = 0;
    int   cyc = 0;

    exp_t       exp_q[$];
    int         shot_cyc[$];
    logic [2:0] exp_h = 3'd0;
    logic       tick_prev = 1'b0;
    logic [3:0] dir_tab [8] = '{4'b0001, 4'b0101, 4'b0100, 4'b0110,
                                4'b0010, 4'b1010, 4'b1000, 4'b1001};

    always #5 clk = ~clk;

    ship_heading_ctrl_if #(.HEADING_BITS(3)) bus ();
    ship_heading_ctrl_if #(.HEADING_BITS(4)) bus16 ();

    ship_heading_ctrl #(
        .TICK_DIV      (TickDiv),
        .HEADING_BITS  (3),
        .RESET_HEADING (0),
        .COOLDOWN_TICKS(Cooldown)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    ship_heading_ctrl #(
        .TICK_DIV      (TickDiv),
        .HEADING_BITS  (4),
        .RESET_HEADING (0),
        .COOLDOWN_TICKS(Cooldown)
    ) u_dut16 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus16)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // Monitor: one negedge after a tick the updated outputs are compared with the queue head.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!reset) begin
            tick_prev <= 1'b0;
        end else begin
            tick_prev <= bus.tick;
            if (tick_prev && exp_q.size() > 0) begin
                check_eq("sb_heading", bus.heading, exp_q[0].heading);
                check_eq("sb_dir", bus.dir, exp_q[0].dir);
                check_eq("sb_move", bus.move, exp_q[0].move);
                void'(exp_q.pop_front());
            end
            if (bus.shot) begin
                shot_cyc.push_back(cyc);
            end
        end
    end

    task automatic sync_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.tick !== 1'b1 && n < 3 * TickDiv);
        check_eq("sync_tick", bus.tick, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 64 * TickDiv) begin
            @(negedge clk);
            n++;
        end
        check_eq("sb_drain", exp_q.size(), 0);
    endtask

    // Hold the given keys for n ticks, queueing the expected state after each tick.
    task automatic run_phase(input logic l, input logic r, input logic t, input int n);
        sync_tick();
        bus.rotate_left  = l;
        bus.rotate_right = r;
        bus.thrust       = t;
        for (int i = 0; i < n; i++) begin
            if (bus.alive) begin
                if (r && !l) exp_h = exp_h + 3'd1;
                else if (l && !r) exp_h = exp_h - 3'd1;
            end
            exp_q.push_back(exp_t'{heading: exp_h, dir: dir_tab[exp_h], move: t & bus.alive});
        end
        drain();
        bus.rotate_left  = 1'b0;
        bus.rotate_right = 1'b0;
        bus.thrust       = 1'b0;
    endtask

    initial begin
        int         n;
        logic [2:0] d;
        bus.rotate_left    = 1'b0;
        bus.rotate_right   = 1'b0;
        bus.thrust         = 1'b0;
        bus.fire           = 1'b0;
        bus.alive          = 1'b1;
        bus16.rotate_left  = 1'b0;
        bus16.rotate_right = 1'b0;
        bus16.thrust       = 1'b0;
        bus16.fire         = 1'b0;
        bus16.alive        = 1'b1;

        repeat (3) @(negedge clk);
        check_eq("rst_heading", bus.heading, 3'd0);
        check_eq("rst_dir", bus.dir, 4'b0001);
        check_eq("rst_move", bus.move, 1'b0);
        check_eq("rst_shot", bus.shot, 1'b0);
        check_eq("rst_tick", bus.tick, 1'b0);
        reset = 1'b1;

        // Tick strobe: one cycle wide, period TickDiv.
        sync_tick();
        @(negedge clk);
        check_eq("tick_width", bus.tick, 1'b0);
        n = 1;
        while (bus.tick !== 1'b1 && n < 3 * TickDiv) begin
            @(negedge clk);
            n++;
        end
        check_eq("tick_period", n, TickDiv);

        run_phase(1'b0, 1'b1, 1'b0, 9);  // 1..7,0,1
        check_eq("right9_heading", bus.heading, 3'd1);
        run_phase(1'b1, 1'b0, 1'b0, 2);  // 0, then wrap to 7
        check_eq("left_wrap_dir", bus.dir, 4'b1001);
        run_phase(1'b1, 1'b1, 1'b0, 3);  // both keys: hold
        run_phase(1'b0, 1'b0, 1'b1, 2);  // thrust only

        // 16-heading instance: three right ticks from north land in octant 1.
        sync_tick();
        bus16.rotate_right = 1'b1;
        repeat (2 * TickDiv + 2) @(negedge clk);
        bus16.rotate_right = 1'b0;
        repeat (TickDiv) @(negedge clk);
        check_eq("h16_heading", bus16.heading, 4'd3);
        check_eq("h16_dir", bus16.dir, 4'b0101);

        // Held fire for 20 cycles.
        repeat (4 * TickDiv) @(negedge clk);
        shot_cyc.delete();
        bus.fire = 1'b1;
        @(negedge clk);
        check_eq("shot_lat1", bus.shot, 1'b0);
        @(negedge clk);
        check_eq("shot_lat2", bus.shot, 1'b1);
        @(negedge clk);
        check_eq("shot_width", bus.shot, 1'b0);
        repeat (17) @(negedge clk);
        bus.fire = 1'b0;
        repeat (4 * TickDiv) @(negedge clk);
`ifdef SHIP_AUTOFIRE_EN
        check_eq("autofire_multi", shot_cyc.size() >= 2, 1'b1);
        for (int i = 1; i < shot_cyc.size(); i++) begin
            check_eq("autofire_gap_min", (shot_cyc[i] - shot_cyc[i-1]) > TickDiv, 1'b1);
            check_eq("autofire_gap_max", (shot_cyc[i] - shot_cyc[i-1]) <= 3 * TickDiv, 1'b1);
        end
`else
        check_eq("held_one_shot", shot_cyc.size(), 1);

        // A press that starts during cooldown is lost; a fresh press in idle fires.
        shot_cyc.delete();
        bus.fire = 1'b1;
        repeat (3) @(negedge clk);
        bus.fire = 1'b0;
        @(negedge clk);
        bus.fire = 1'b1;
        repeat (3) @(negedge clk);
        bus.fire = 1'b0;
        repeat (4 * TickDiv) @(negedge clk);
        check_eq("cool_edge_lost", shot_cyc.size(), 1);
        bus.fire = 1'b1;
        repeat (3) @(negedge clk);
        bus.fire = 1'b0;
        repeat (4 * TickDiv) @(negedge clk);
        check_eq("refire_idle", shot_cyc.size(), 2);
`endif

        // Dead ship: heading frozen, move dropped, no shots; resumes when alive again.
        run_phase(1'b0, 1'b0, 1'b1, 1);
        check_eq("pre_dead_move", bus.move, 1'b1);
        shot_cyc.delete();
        bus.alive = 1'b0;
        bus.fire  = 1'b1;
        run_phase(1'b0, 1'b1, 1'b1, 2);
        check_eq("dead_no_shot", shot_cyc.size(), 0);
        bus.alive = 1'b1;
        run_phase(1'b0, 1'b1, 1'b1, 1);
        bus.fire = 1'b0;
        repeat (4 * TickDiv) @(negedge clk);

        // Reset in the middle of a cooldown with heading 5 and move set.
        d = 3'd5 - exp_h;
        if (d != 3'd0) run_phase(1'b0, 1'b1, 1'b0, int'(d));
        bus.thrust = 1'b1;
        sync_tick();
        @(negedge clk);
        check_eq("pre_rst_heading", bus.heading, 3'd5);
        check_eq("pre_rst_move", bus.move, 1'b1);
        shot_cyc.delete();
        bus.fire = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("pre_rst_shot_seen", shot_cyc.size(), 1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("async_rst_heading", bus.heading, 3'd0);
        check_eq("async_rst_dir", bus.dir, 4'b0001);
        check_eq("async_rst_move", bus.move, 1'b0);
        check_eq("async_rst_shot", bus.shot, 1'b0);
        check_eq("async_rst_tick", bus.tick, 1'b0);
        exp_q.delete();
        exp_h      = 3'd0;
        bus.fire   = 1'b0;
        bus.thrust = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.tick !== 1'b1 && n < 4 * TickDiv);
        check_eq("first_tick_bound", (bus.tick === 1'b1) && (n <= TickDiv), 1'b1);

        // Fire edge from idle after reset.
        bus.fire = 1'b1;
        @(negedge clk);
        check_eq("post_rst_lat1", bus.shot, 1'b0);
        @(negedge clk);
        check_eq("post_rst_shot", bus.shot, 1'b1);
        bus.fire = 1'b0;
        repeat (4 * TickDiv) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
